// File: rtl/alu_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_sequencer_pkg
// Shared definitions for the ALU sequencer: datapath widths, ALU opcode
// constants, immediate-form op_hi codes, flag bit positions, FSM state
// encoding, decoded-instruction record and operand-extension helpers.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_sequencer_pkg;

   localparam int DATA_W     = 16;
   localparam int REG_ADDR_W = 4;
   localparam int FLAG_W     = 5;
   localparam int OPC_W      = 8;

   // ALU opcodes as driven on alu_opcode
   localparam logic [7:0] OPC_WAIT = 8'h00;
   localparam logic [7:0] OPC_AND  = 8'h01;
   localparam logic [7:0] OPC_OR   = 8'h02;
   localparam logic [7:0] OPC_XOR  = 8'h03;
   localparam logic [7:0] OPC_LSH  = 8'h04;
   localparam logic [7:0] OPC_ADD  = 8'h05;
   localparam logic [7:0] OPC_ADDU = 8'h06;
   localparam logic [7:0] OPC_ADDC = 8'h07;
   localparam logic [7:0] OPC_ARSH = 8'h08;
   localparam logic [7:0] OPC_SUB  = 8'h09;
   localparam logic [7:0] OPC_SUBC = 8'h0A;
   localparam logic [7:0] OPC_CMP  = 8'h0B;
   localparam logic [7:0] OPC_MOV  = 8'h0D;

   // Compare shares one nibble code in both register (op_ext) and immediate (op_hi) forms
   localparam logic [3:0] CODE_CMP = 4'hB;

   // op_hi codes
   localparam logic [3:0] OPHI_REG   = 4'h0;
   localparam logic [3:0] OPHI_ADDI  = 4'h5;
   localparam logic [3:0] OPHI_ADDUI = 4'h6;
   localparam logic [3:0] OPHI_ADDCI = 4'h7;
   localparam logic [3:0] OPHI_SUBI  = 4'h9;
   localparam logic [3:0] OPHI_CMPI  = CODE_CMP;

   // Flag bit positions inside the 5-bit flags word
   localparam int FLAG_Z = 4;
   localparam int FLAG_C = 3;
   localparam int FLAG_F = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_L = 0;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_READ = 3'd1,
      ST_EXEC = 3'd2,
      ST_WB   = 3'd3,
      ST_HALT = 3'd4
   } state_t;

   typedef struct packed {
      logic [OPC_W-1:0]      opcode;
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_ADDR_W-1:0] rs;
      logic                  use_imm;
      logic [DATA_W-1:0]     imm_ext;
      logic                  is_cmp;
      logic                  is_wait;
      logic                  is_illegal;
   } dec_t;

   function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
      return {{(DATA_W-8){v[7]}}, v};
   endfunction

   function automatic logic [DATA_W-1:0] zext8(input logic [7:0] v);
      return {{(DATA_W-8){1'b0}}, v};
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_sequencer_if
// Bundles the sequencer's instruction handshake, register-file ports, ALU
// ports and status outputs.
//   master : the sequencer (drives instr_ready, rf_*addr/we/wdata, alu_a/b/
//            opcode, flags, halted, illegal)
//   slave  : the surrounding fetch / register file / ALU environment
// ---------------------------------------------------------------------------
interface alu_sequencer_if;
   import alu_sequencer_pkg::*;

   logic [DATA_W-1:0]     instr;
   logic                  instr_valid;
   logic                  instr_ready;
   logic                  resume;
   logic [REG_ADDR_W-1:0] rf_raddr_a;
   logic [REG_ADDR_W-1:0] rf_raddr_b;
   logic [DATA_W-1:0]     rf_rdata_a;
   logic [DATA_W-1:0]     rf_rdata_b;
   logic                  rf_we;
   logic [REG_ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0]     rf_wdata;
   logic [DATA_W-1:0]     alu_a;
   logic [DATA_W-1:0]     alu_b;
   logic [OPC_W-1:0]      alu_opcode;
   logic [DATA_W-1:0]     alu_c;
   logic [FLAG_W-1:0]     alu_flags;
   logic [FLAG_W-1:0]     flags;
   logic                  halted;
   logic                  illegal;

   modport master (
      input  instr, instr_valid, resume, rf_rdata_a, rf_rdata_b, alu_c, alu_flags,
      output instr_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
             alu_a, alu_b, alu_opcode, flags, halted, illegal
   );

   modport slave (
      output instr, instr_valid, resume, rf_rdata_a, rf_rdata_b, alu_c, alu_flags,
      input  instr_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
             alu_a, alu_b, alu_opcode, flags, halted, illegal
   );

endinterface

// File: rtl/alu_sequencer_decode.sv
// ---------------------------------------------------------------------------
// alu_sequencer_decode
// Purely combinational instruction decoder.
//   instr : 16-bit instruction word
//   dec   : decoded record {opcode, rd, rs, use_imm, imm_ext, is_cmp,
//           is_wait, is_illegal}
// ---------------------------------------------------------------------------
module alu_sequencer_decode
   import alu_sequencer_pkg::*;
(
   input  logic [DATA_W-1:0] instr,
   output dec_t              dec
);

   logic [3:0] op_hi_s;
   logic [3:0] op_ext_s;
   logic [7:0] imm_s;

   assign op_hi_s  = instr[15:12];
   assign op_ext_s = instr[7:4];
   assign imm_s    = instr[7:0];

   // Field extraction and form classification
   always_comb begin
      dec            = '0;
      dec.rd         = instr[11:8];
      dec.rs         = instr[3:0];
      case (op_hi_s)
         OPHI_REG: begin
            // All-zero word is WAIT, not a register-form op with op_ext 0
            if (instr == 16'h0000) begin
               dec.is_wait = 1'b1;
            end else begin
               dec.opcode = {4'h0, op_ext_s};
               dec.is_cmp = (op_ext_s == CODE_CMP);
            end
         end
         OPHI_ADDI, OPHI_ADDCI, OPHI_SUBI, OPHI_CMPI: begin
            dec.use_imm = 1'b1;
            dec.imm_ext = sext8(imm_s);
            dec.opcode  = {4'h0, op_hi_s};
            dec.is_cmp  = (op_hi_s == OPHI_CMPI);
         end
         OPHI_ADDUI: begin
            dec.use_imm = 1'b1;
            dec.imm_ext = zext8(imm_s);
            dec.opcode  = {4'h0, op_hi_s};
         end
         default: begin
            dec.is_illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Multi-cycle controller issuing one instruction at a time to a 16-bit ALU:
// IDLE (accept/decode) -> READ (operand fetch) -> EXEC (ALU, flags) -> WB
// (register write-back); WAIT parks in HALT until a resume pulse.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : master side of alu_sequencer_if (fetch handshake, register file,
//           ALU, flags/halted/illegal status)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module alu_sequencer
   import alu_sequencer_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   alu_sequencer_if.master bus
);

   state_t                state_r;
   state_t                state_nxt_s;
   logic [DATA_W-1:0]     instr_r;
   logic [DATA_W-1:0]     dec_in_s;
   dec_t                  dec_s;
   logic                  accept_s;
   logic                  illegal_nxt_s;
   logic [DATA_W-1:0]     opa_r;
   logic [DATA_W-1:0]     opb_r;
   logic [DATA_W-1:0]     result_r;
   logic [FLAG_W-1:0]     flags_r;
   logic [OPC_W-1:0]      opcode_r;
   logic [REG_ADDR_W-1:0] raddr_a_r;
   logic [REG_ADDR_W-1:0] raddr_b_r;
   logic                  we_r;
   logic                  ready_r;
   logic                  halted_r;
   logic                  illegal_r;

   // In IDLE the live word is decoded for the accept decision; afterwards the latched one
   assign dec_in_s = (state_r == ST_IDLE) ? bus.instr : instr_r;

   alu_sequencer_decode u_decode (
      .instr (dec_in_s),
      .dec   (dec_s)
   );

   // ready_r is the registered copy of "next state is IDLE", so it also gates acceptance
   assign accept_s = (state_r == ST_IDLE) && ready_r && bus.instr_valid;

   // Next-state and illegal-pulse logic
   always_comb begin
      state_nxt_s   = state_r;
      illegal_nxt_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (dec_s.is_wait) begin
                  state_nxt_s = ST_HALT;
               end else if (dec_s.is_illegal) begin
                  state_nxt_s   = ST_IDLE;
                  illegal_nxt_s = 1'b1;
               end else begin
                  state_nxt_s = ST_READ;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_READ: state_nxt_s = ST_EXEC;
         ST_EXEC: begin
            if (dec_s.is_cmp) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_WB;
            end
         end
         ST_WB:   state_nxt_s = ST_IDLE;
         ST_HALT: begin
            if (bus.resume) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_HALT;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Status/control outputs registered from the next state so they line up with it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ready_r   <= 1'b0;
         halted_r  <= 1'b0;
         we_r      <= 1'b0;
         illegal_r <= 1'b0;
         opcode_r  <= 8'h00;
      end else begin
         ready_r   <= (state_nxt_s == ST_IDLE);
         halted_r  <= (state_nxt_s == ST_HALT);
         we_r      <= (state_nxt_s == ST_WB);
         illegal_r <= illegal_nxt_s;
         opcode_r  <= (state_nxt_s == ST_EXEC) ? dec_s.opcode : 8'h00;
      end
   end

   // Instruction latch and register-file addresses, captured only for instructions that run
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_r   <= 16'h0000;
         raddr_a_r <= 4'h0;
         raddr_b_r <= 4'h0;
      end else if (accept_s && (state_nxt_s == ST_READ)) begin
         instr_r   <= bus.instr;
         raddr_a_r <= dec_s.rd;
         raddr_b_r <= dec_s.rs;
      end else begin
         instr_r   <= instr_r;
         raddr_a_r <= raddr_a_r;
         raddr_b_r <= raddr_b_r;
      end
   end

   // Operand capture in READ, result and flags capture in EXEC
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         opa_r    <= 16'h0000;
         opb_r    <= 16'h0000;
         result_r <= 16'h0000;
         flags_r  <= 5'b00000;
      end else if (state_r == ST_READ) begin
         opa_r <= bus.rf_rdata_a;
         opb_r <= dec_s.use_imm ? dec_s.imm_ext : bus.rf_rdata_b;
      end else if (state_r == ST_EXEC) begin
         result_r <= bus.alu_c;
         flags_r  <= bus.alu_flags;
      end else begin
         opa_r    <= opa_r;
         opb_r    <= opb_r;
         result_r <= result_r;
         flags_r  <= flags_r;
      end
   end

   assign bus.instr_ready = ready_r;
   assign bus.rf_raddr_a  = raddr_a_r;
   assign bus.rf_raddr_b  = raddr_b_r;
   assign bus.rf_we       = we_r;
   assign bus.rf_waddr    = raddr_a_r;
   assign bus.rf_wdata    = result_r;
   assign bus.alu_a       = opa_r;
   assign bus.alu_b       = opb_r;
   assign bus.alu_opcode  = opcode_r;
   assign bus.flags       = flags_r;
   assign bus.halted      = halted_r;
   assign bus.illegal     = illegal_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
// Self-checking bench: behavioural register file and ALU around the
// sequencer, a table of instruction vectors, a write-back scoreboard, and
// hand-written HALT / illegal / mid-operation reset sequences.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;
   import alu_sequencer_pkg::*;

   logic clk = 1'b0;
   logic reset;

   alu_sequencer_if bus ();

   alu_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int acc_cyc  = 0;
   int exec_cnt = 0;
   logic [7:0]  last_opc;
   logic [15:0] last_b;

   typedef struct packed {
      logic [3:0]  addr;
      logic [15:0] data;
   } wr_t;
   wr_t sb[$];

   typedef struct {
      logic [15:0] instr;
      logic [3:0]  a_addr;
      logic [15:0] a_val;
      logic [3:0]  b_addr;
      logic [15:0] b_val;
      logic [7:0]  exp_opc;
      logic [15:0] exp_b;
      logic        exp_we;
      logic [3:0]  exp_addr;
      logic [15:0] exp_data;
      logic [4:0]  exp_flags;
   } vec_t;
   vec_t vecs[10];

   // ---------------- environment: register file ----------------
   logic [15:0] regs [16];
   logic        seed_we;
   logic [3:0]  seed_addr;
   logic [15:0] seed_data;

   always @(posedge clk) begin
      if (seed_we) regs[seed_addr] <= seed_data;
      else if (bus.rf_we) regs[bus.rf_waddr] <= bus.rf_wdata;
   end

   assign bus.rf_rdata_a = regs[bus.rf_raddr_a];
   assign bus.rf_rdata_b = regs[bus.rf_raddr_b];

   // ---------------- environment: ALU ----------------
   logic [16:0] alu_sum;
   always_comb begin
      alu_sum       = 17'd0;
      bus.alu_c     = 16'h0000;
      bus.alu_flags = 5'b00000;
      case (bus.alu_opcode)
         OPC_AND: bus.alu_c = bus.alu_a & bus.alu_b;
         OPC_OR:  bus.alu_c = bus.alu_a | bus.alu_b;
         OPC_XOR: bus.alu_c = bus.alu_a ^ bus.alu_b;
         OPC_MOV: bus.alu_c = bus.alu_b;
         OPC_LSH: bus.alu_c = bus.alu_a << bus.alu_b[3:0];
         OPC_ARSH: bus.alu_c = $signed(bus.alu_a) >>> bus.alu_b[3:0];
         OPC_ADD, OPC_ADDU, OPC_ADDC: begin
            alu_sum   = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            bus.alu_c = alu_sum[15:0];
            bus.alu_flags[FLAG_C] = alu_sum[16];
            bus.alu_flags[FLAG_F] = (bus.alu_a[15] == bus.alu_b[15]) && (alu_sum[15] != bus.alu_a[15]);
         end
         OPC_SUB, OPC_SUBC: begin
            bus.alu_c = bus.alu_a - bus.alu_b;
            bus.alu_flags[FLAG_C] = (bus.alu_a < bus.alu_b);
            bus.alu_flags[FLAG_F] = (bus.alu_a[15] != bus.alu_b[15]) && ((bus.alu_a[15] ^ (bus.alu_a - bus.alu_b) >> 15) == 16'h0001);
         end
         OPC_CMP: begin
            bus.alu_flags[FLAG_L] = (bus.alu_a < bus.alu_b);
            bus.alu_flags[FLAG_N] = ($signed(bus.alu_a) < $signed(bus.alu_b));
         end
         default: bus.alu_c = 16'h0000;
      endcase
      if (bus.alu_opcode == OPC_CMP) bus.alu_flags[FLAG_Z] = (bus.alu_a == bus.alu_b);
      else bus.alu_flags[FLAG_Z] = (bus.alu_c == 16'h0000);
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // cycle counter
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: EXEC observation and write-back scoreboard, sampled on the falling edge
   initial forever begin
      @(negedge clk);
      if (bus.alu_opcode != 8'h00) begin
         exec_cnt++;
         last_opc = bus.alu_opcode;
         last_b   = bus.alu_b;
      end
      if (bus.rf_we === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL wr_unexpected addr=%0h data=%0h (t=%0t)", bus.rf_waddr, bus.rf_wdata, $time);
         end else begin
            wr_t e;
            e = sb.pop_front();
            check("wr_addr", {28'h0, bus.rf_waddr}, {28'h0, e.addr});
            check("wr_data", {16'h0, bus.rf_wdata}, {16'h0, e.data});
            check("wr_cycle", cyc - acc_cyc, 32'd3);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout (t=%0t)", $time);
      $fatal(1, "bench timeout");
   end

   task automatic seed(input logic [3:0] a, input logic [15:0] d);
      seed_we   = 1'b1;
      seed_addr = a;
      seed_data = d;
      @(posedge clk);
      #1;
      seed_we = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (bus.instr_ready !== 1'b1 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("ready_wait", {31'h0, bus.instr_ready}, 32'd1);
   endtask

   task automatic run_vec(input vec_t v);
      int k;
      int e0;
      seed(v.a_addr, v.a_val);
      seed(v.b_addr, v.b_val);
      wait_ready();
      bus.instr       = v.instr;
      bus.instr_valid = 1'b1;
      acc_cyc         = cyc;
      e0              = exec_cnt;
      if (v.exp_we) sb.push_back({v.exp_addr, v.exp_data});
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      k = 1;
      while (bus.instr_ready !== 1'b1 && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("ready_latency", k, v.exp_we ? 32'd4 : 32'd3);
      check("exec_cycles", exec_cnt - e0, 32'd1);
      check("alu_opcode", {24'h0, last_opc}, {24'h0, v.exp_opc});
      check("alu_b", {16'h0, last_b}, {16'h0, v.exp_b});
      check("flags", {27'h0, bus.flags}, {27'h0, v.exp_flags});
      check("reg_value", {16'h0, regs[v.exp_addr]}, {16'h0, v.exp_data});
      check("sb_drained", sb.size(), 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int e0;
      vecs[0] = '{16'h0152, 4'h1, 16'h7FFF, 4'h2, 16'h0001, 8'h05, 16'h0001, 1'b1, 4'h1, 16'h8000, 5'b00100};
      vecs[1] = '{16'h6301, 4'h3, 16'hFFFF, 4'h3, 16'hFFFF, 8'h06, 16'h0001, 1'b1, 4'h3, 16'h0000, 5'b11000};
      vecs[2] = '{16'h04B5, 4'h4, 16'h0005, 4'h5, 16'h0009, 8'h0B, 16'h0009, 1'b0, 4'h4, 16'h0005, 5'b00011};
      vecs[3] = '{16'h5AFF, 4'hA, 16'h0003, 4'hB, 16'h1234, 8'h05, 16'hFFFF, 1'b1, 4'hA, 16'h0002, 5'b01000};
      vecs[4] = '{16'h6AFF, 4'hA, 16'h0003, 4'hB, 16'h1234, 8'h06, 16'h00FF, 1'b1, 4'hA, 16'h0102, 5'b00000};
      vecs[5] = '{16'h0617, 4'h6, 16'hF0F0, 4'h7, 16'h3C3C, 8'h01, 16'h3C3C, 1'b1, 4'h6, 16'h3030, 5'b00000};
      vecs[6] = '{16'h0833, 4'h8, 16'hAAAA, 4'h3, 16'hAAAA, 8'h03, 16'hAAAA, 1'b1, 4'h8, 16'h0000, 5'b10000};
      vecs[7] = '{16'h9C80, 4'hC, 16'h0000, 4'hD, 16'h5555, 8'h09, 16'hFF80, 1'b1, 4'hC, 16'h0080, 5'b01000};
      vecs[8] = '{16'hBD05, 4'hD, 16'h0005, 4'hE, 16'h7777, 8'h0B, 16'h0005, 1'b0, 4'hD, 16'h0005, 5'b10000};
      vecs[9] = '{16'h7E80, 4'hE, 16'h0080, 4'hF, 16'h1111, 8'h07, 16'hFF80, 1'b1, 4'hE, 16'h0000, 5'b11000};

      reset           = 1'b1;
      bus.instr       = 16'h0000;
      bus.instr_valid = 1'b0;
      bus.resume      = 1'b0;
      seed_we         = 1'b0;
      seed_addr       = 4'h0;
      seed_data       = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rf_we", {31'h0, bus.rf_we}, 32'd0);
      check("rst_ready", {31'h0, bus.instr_ready}, 32'd0);
      check("rst_flags", {27'h0, bus.flags}, 32'd0);
      check("rst_halted", {31'h0, bus.halted}, 32'd0);
      check("rst_illegal", {31'h0, bus.illegal}, 32'd0);
      check("rst_opcode", {24'h0, bus.alu_opcode}, 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_ready", {31'h0, bus.instr_ready}, 32'd1);

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // illegal encoding: one-cycle pulse, stays ready, flags untouched
      wait_ready();
      e0              = exec_cnt;
      bus.instr       = 16'hF123;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      check("ill_pulse", {31'h0, bus.illegal}, 32'd1);
      check("ill_ready", {31'h0, bus.instr_ready}, 32'd1);
      @(posedge clk);
      #1;
      check("ill_pulse_end", {31'h0, bus.illegal}, 32'd0);
      check("ill_flags", {27'h0, bus.flags}, {27'h0, 5'b11000});
      check("ill_no_exec", exec_cnt - e0, 32'd0);

      // resume outside HALT has no effect
      bus.resume = 1'b1;
      @(posedge clk);
      #1;
      bus.resume = 1'b0;
      check("stray_resume_ready", {31'h0, bus.instr_ready}, 32'd1);
      check("stray_resume_halted", {31'h0, bus.halted}, 32'd0);

      // WAIT -> HALT; held instr_valid is ignored for 10 cycles
      wait_ready();
      bus.instr       = 16'h0000;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      #1;
      check("halt_enter", {31'h0, bus.halted}, 32'd1);
      check("halt_ready", {31'h0, bus.instr_ready}, 32'd0);
      bus.instr = 16'h0152;
      e0        = exec_cnt;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("halt_hold", {31'h0, bus.halted}, 32'd1);
      end
      check("halt_no_exec", exec_cnt - e0, 32'd0);
      check("halt_flags", {27'h0, bus.flags}, {27'h0, 5'b11000});
      bus.instr_valid = 1'b0;
      bus.resume      = 1'b1;
      @(posedge clk);
      #1;
      bus.resume = 1'b0;
      check("resume_halted", {31'h0, bus.halted}, 32'd0);
      check("resume_ready", {31'h0, bus.instr_ready}, 32'd1);
      run_vec(vecs[0]);

      // reset during EXEC drops the instruction
      seed(4'h1, 16'h7FFF);
      seed(4'h2, 16'h0001);
      wait_ready();
      bus.instr       = 16'h0152;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      @(posedge clk);
      #1;
      check("pre_rst_exec", {24'h0, bus.alu_opcode}, 32'h05);
      reset = 1'b1;
      #1;
      check("midrst_flags", {27'h0, bus.flags}, 32'd0);
      check("midrst_we", {31'h0, bus.rf_we}, 32'd0);
      check("midrst_opcode", {24'h0, bus.alu_opcode}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("midrst_reg", {16'h0, regs[1]}, 32'h7FFF);
      check("midrst_ready", {31'h0, bus.instr_ready}, 32'd1);
      check("midrst_flags_after", {27'h0, bus.flags}, 32'd0);
      check("midrst_sb", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
